// File: rtl/ysyx_24090013_ex_ctrl_if.sv
// Purpose : bundles the ID issue handshake, the ALU issue path, the long-unit
//           path and the regfile write port that the EX controller owns.
// Ports   : slave  = controller view (drives id_ready, alu_*, long_start, wb_*,
//                    busy, stall_cycles).
//           master = environment view (drives id_*, alu_rd_data, long_rd_data).
interface ysyx_24090013_ex_ctrl_if;
   // ID -> controller
   logic        id_valid;
   logic        id_ready;
   logic        id_long;
   logic [3:0]  id_aluc;
   logic [7:0]  id_alucex;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic [4:0]  id_rd_addr;
   logic        id_rd_wen;
   // controller <-> EX datapath
   logic        alu_fire;
   logic [3:0]  alu_aluc;
   logic [7:0]  alu_alucex;
   logic [31:0] alu_rd_data;
   // controller <-> long unit
   logic        long_start;
   logic [31:0] long_rd_data;
   // regfile write port and status
   logic        wb_wen;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        busy;
   logic [31:0] stall_cycles;

   modport slave (
      input  id_valid, id_long, id_aluc, id_alucex, id_rs1_addr, id_rs2_addr,
             id_rd_addr, id_rd_wen, alu_rd_data, long_rd_data,
      output id_ready, alu_fire, alu_aluc, alu_alucex, long_start,
             wb_wen, wb_addr, wb_data, busy, stall_cycles
   );

   modport master (
      output id_valid, id_long, id_aluc, id_alucex, id_rs1_addr, id_rs2_addr,
             id_rd_addr, id_rd_wen, alu_rd_data, long_rd_data,
      input  id_ready, alu_fire, alu_aluc, alu_alucex, long_start,
             wb_wen, wb_addr, wb_data, busy, stall_cycles
   );
endinterface

// File: rtl/ysyx_24090013_ex_ctrl.sv
// Purpose : ID->EX issue/writeback controller; issues single-cycle ALU ops,
//           sequences one fixed-latency long op and owns the regfile write port.
// Latency : ALU op accepted at t writes back at t+1; long op accepted at t
//           pulses long_start at t+1 and writes back at t+LONG_LAT+1.
// Backpr. : id_ready is combinational; it drops while a long op is running and
//           the incoming op is long, hazards on the long rd, or would collide
//           with the long writeback (last RUN cycle).
// Ports   : clk, rst (sync, active-high) plus the slave modport of
//           ysyx_24090013_ex_ctrl_if.
module ysyx_24090013_ex_ctrl #(
   parameter int LONG_LAT = 8   // legal range 2..255
) (
   input  logic                           clk,
   input  logic                           rst,
   ysyx_24090013_ex_ctrl_if.slave         bus
);

   localparam logic [7:0] LAT = 8'(LONG_LAT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [4:0]  long_rd_q;
   logic        long_wen_q;
   logic        long_start_q;
   logic        wb_wen_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] wb_data_q;
   logic [31:0] stall_q;
   logic [31:0] stall_d;

   logic ready_c;
   logic accept_c;
   logic long_acc_c;
   logic alu_acc_c;
   logic last_run_c;
   logic haz_c;
   logic long_rd_nz_c;
   logic done_wen_c;

   // ------------------------------------------------------------------
   // Acceptance / hazard logic
   // ------------------------------------------------------------------
   assign long_rd_nz_c = (long_rd_q != 5'd0);
   assign last_run_c   = (state_q == S_RUN) && (cnt_q == 8'd1);

   // RAW on either source or WAW on rd against the in-flight long op; x0
   // never creates a dependency.
   assign haz_c = long_rd_nz_c &&
                  ((bus.id_rs1_addr == long_rd_q) ||
                   (bus.id_rs2_addr == long_rd_q) ||
                   (bus.id_rd_wen && (bus.id_rd_addr == long_rd_q)));

   always_comb begin
      ready_c = 1'b1;
      if (state_q == S_RUN) begin
         // Blocking at the last RUN cycle keeps DONE free of ALU writebacks,
         // so the single write port never sees two writers.
         ready_c = !(bus.id_long || last_run_c || haz_c);
      end
   end

   assign accept_c   = bus.id_valid && ready_c;
   assign long_acc_c = accept_c && bus.id_long;
   assign alu_acc_c  = accept_c && !bus.id_long;

   assign stall_d = (bus.id_valid && !ready_c) ? stall_q + 32'd1 : stall_q;

   // ------------------------------------------------------------------
   // FSM and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         long_rd_q    <= 5'd0;
         long_wen_q   <= 1'b0;
         long_start_q <= 1'b0;
         wb_wen_q     <= 1'b0;
         wb_addr_q    <= 5'd0;
         wb_data_q    <= 32'd0;
         stall_q      <= 32'd0;
      end else begin
         long_start_q <= 1'b0;
         wb_wen_q     <= 1'b0;
         stall_q      <= stall_d;

         // ALU results are registered for the t+1 writeback. In DONE without
         // an ALU accept, capture the long result so address/data hold the
         // last written values afterwards.
         if (alu_acc_c) begin
            wb_wen_q  <= bus.id_rd_wen && (bus.id_rd_addr != 5'd0);
            wb_addr_q <= bus.id_rd_addr;
            wb_data_q <= bus.alu_rd_data;
         end else if (state_q == S_DONE) begin
            wb_addr_q <= long_rd_q;
            wb_data_q <= bus.long_rd_data;
         end

         case (state_q)
            S_IDLE: begin
               if (long_acc_c) begin
                  long_rd_q    <= bus.id_rd_addr;
                  long_wen_q   <= bus.id_rd_wen;
                  cnt_q        <= LAT;
                  long_start_q <= 1'b1;
                  state_q      <= S_RUN;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               // A back-to-back long op may be accepted while the previous
               // one writes back; its rd is latched after the current write.
               if (long_acc_c) begin
                  long_rd_q    <= bus.id_rd_addr;
                  long_wen_q   <= bus.id_rd_wen;
                  cnt_q        <= LAT;
                  long_start_q <= 1'b1;
                  state_q      <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output drive. The long writeback is combinational in DONE because the
   // long unit only presents its result in that cycle.
   // ------------------------------------------------------------------
   assign done_wen_c = long_wen_q && long_rd_nz_c;

   assign bus.id_ready     = ready_c;
   assign bus.alu_fire     = alu_acc_c;
   assign bus.alu_aluc     = bus.id_aluc;
   assign bus.alu_alucex   = bus.id_alucex;
   assign bus.long_start   = long_start_q;
   assign bus.wb_wen       = (state_q == S_DONE) ? done_wen_c : wb_wen_q;
   assign bus.wb_addr      = (state_q == S_DONE) ? long_rd_q : wb_addr_q;
   assign bus.wb_data      = (state_q == S_DONE) ? bus.long_rd_data : wb_data_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_ysyx_24090013_ex_ctrl.sv
// Purpose : directed self-checking bench for ysyx_24090013_ex_ctrl.
// Ports   : none; instantiates the interface and the controller with LONG_LAT=8.
module tb_ysyx_24090013_ex_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ysyx_24090013_ex_ctrl_if bus_if ();

   ysyx_24090013_ex_ctrl #(.LONG_LAT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
      logic [3:0]  aluc;
      logic [7:0]  alucex;
      logic        exp_wen;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // drive point: just after the active edge; sample point: falling edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_in();
      bus_if.id_valid    = 1'b0;
      bus_if.id_long     = 1'b0;
      bus_if.id_aluc     = 4'd0;
      bus_if.id_alucex   = 8'd0;
      bus_if.id_rs1_addr = 5'd0;
      bus_if.id_rs2_addr = 5'd0;
      bus_if.id_rd_addr  = 5'd0;
      bus_if.id_rd_wen   = 1'b0;
   endtask

   task automatic op(input logic lng, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic wen, input logic [31:0] adata);
      bus_if.id_valid    = 1'b1;
      bus_if.id_long     = lng;
      bus_if.id_rs1_addr = rs1;
      bus_if.id_rs2_addr = rs2;
      bus_if.id_rd_addr  = rd;
      bus_if.id_rd_wen   = wen;
      bus_if.alu_rd_data = adata;
   endtask

   task automatic chk_wb(input string name, input logic wen, input logic [4:0] addr,
                         input logic [31:0] data);
      chk({name, ".wen"},  {31'd0, bus_if.wb_wen}, {31'd0, wen});
      chk({name, ".addr"}, {27'd0, bus_if.wb_addr}, {27'd0, addr});
      chk({name, ".data"}, bus_if.wb_data, data);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_in();
      bus_if.alu_rd_data  = 32'd0;
      bus_if.long_rd_data = 32'd0;

      vecs[0] = '{5'd5,  1'b1, 32'h0000_0010, 4'h1, 8'h11, 1'b1, 5'd5,  32'h0000_0010};
      vecs[1] = '{5'd0,  1'b1, 32'h0000_DEAD, 4'h2, 8'h22, 1'b0, 5'd0,  32'h0000_DEAD};
      vecs[2] = '{5'd31, 1'b1, 32'hFFFF_FFFF, 4'hF, 8'hFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
      vecs[3] = '{5'd12, 1'b0, 32'h0000_1234, 4'h7, 8'h5A, 1'b0, 5'd12, 32'h0000_1234};
      vecs[4] = '{5'd1,  1'b1, 32'h0000_0000, 4'h3, 8'hA5, 1'b1, 5'd1,  32'h0000_0000};

      cyc(); cyc();
      rst = 1'b0;
      mid();
      // ---------------- reset state ----------------
      chk_wb("reset", 1'b0, 5'd0, 32'd0);
      chk("reset.busy",       {31'd0, bus_if.busy}, 32'd0);
      chk("reset.long_start", {31'd0, bus_if.long_start}, 32'd0);
      chk("reset.stall",      bus_if.stall_cycles, 32'd0);
      chk("reset.ready",      {31'd0, bus_if.id_ready}, 32'd1);

      // ---------------- table-driven ALU ops in IDLE ----------------
      for (int i = 0; i < 5; i++) begin
         cyc();
         op(1'b0, 5'd0, 5'd0, vecs[i].rd, vecs[i].wen, vecs[i].data);
         bus_if.id_aluc   = vecs[i].aluc;
         bus_if.id_alucex = vecs[i].alucex;
         mid();
         chk($sformatf("v%0d.ready", i), {31'd0, bus_if.id_ready}, 32'd1);
         chk($sformatf("v%0d.fire", i),  {31'd0, bus_if.alu_fire}, 32'd1);
         chk($sformatf("v%0d.aluc", i),  {28'd0, bus_if.alu_aluc}, {28'd0, vecs[i].aluc});
         chk($sformatf("v%0d.alucex", i), {24'd0, bus_if.alu_alucex}, {24'd0, vecs[i].alucex});
         cyc();
         idle_in();
         mid();
         chk_wb($sformatf("v%0d.wb", i), vecs[i].exp_wen, vecs[i].exp_addr, vecs[i].exp_data);
      end
      cyc();
      mid();
      chk_wb("hold", 1'b0, 5'd1, 32'd0);

      // ---------------- long op rd=7 with RAW stall (tests 3/4) ----------------
      cyc(); op(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 32'd0);           // t=0
      mid(); chk("L.t0.ready", {31'd0, bus_if.id_ready}, 32'd1);
      chk("L.t0.fire", {31'd0, bus_if.alu_fire}, 32'd0);
      cyc(); idle_in();                                           // t=1
      mid(); chk("L.t1.start", {31'd0, bus_if.long_start}, 32'd1);
      chk("L.t1.busy", {31'd0, bus_if.busy}, 32'd1);
      cyc();                                                      // t=2
      mid(); chk("L.t2.start", {31'd0, bus_if.long_start}, 32'd0);
      cyc(); op(1'b0, 5'd2, 5'd0, 5'd3, 1'b1, 32'h33);            // t=3
      mid(); chk("L.t3.ready", {31'd0, bus_if.id_ready}, 32'd1);
      cyc(); op(1'b0, 5'd7, 5'd0, 5'd4, 1'b1, 32'h44);            // t=4
      mid(); chk_wb("L.t4.wb", 1'b1, 5'd3, 32'h33);
      chk("L.t4.ready", {31'd0, bus_if.id_ready}, 32'd0);
      for (int t = 5; t <= 8; t++) begin
         cyc(); mid();
         chk($sformatf("L.t%0d.ready", t), {31'd0, bus_if.id_ready}, 32'd0);
         chk($sformatf("L.t%0d.wen", t),   {31'd0, bus_if.wb_wen}, 32'd0);
      end
      cyc(); bus_if.long_rd_data = 32'hABCD;                      // t=9 DONE
      mid(); chk_wb("L.t9.wb", 1'b1, 5'd7, 32'hABCD);
      chk("L.t9.ready", {31'd0, bus_if.id_ready}, 32'd1);
      chk("L.t9.busy",  {31'd0, bus_if.busy}, 32'd1);
      cyc(); idle_in(); bus_if.long_rd_data = 32'd0;              // t=10
      mid(); chk_wb("L.t10.wb", 1'b1, 5'd4, 32'h44);
      chk("L.t10.busy",  {31'd0, bus_if.busy}, 32'd0);
      chk("L.t10.stall", bus_if.stall_cycles, 32'd5);

      // ---------------- long op rd=9: WAW / rs2 / long / cnt==1 stalls (test 5) ----
      cyc(); op(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0);             // t=0
      cyc(); idle_in();                                           // t=1
      cyc();                                                      // t=2
      cyc(); op(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 32'h1);             // t=3 WAW
      mid(); chk("W.t3.ready", {31'd0, bus_if.id_ready}, 32'd0);
      cyc(); op(1'b0, 5'd0, 5'd9, 5'd11, 1'b1, 32'h2);            // t=4 rs2 RAW
      mid(); chk("W.t4.ready", {31'd0, bus_if.id_ready}, 32'd0);
      cyc(); op(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 32'h3);            // t=5 long while busy
      mid(); chk("W.t5.ready", {31'd0, bus_if.id_ready}, 32'd0);
      cyc(); op(1'b0, 5'd1, 5'd2, 5'd0, 1'b0, 32'h0);             // t=6 no hazard (rd=x0)
      mid(); chk("W.t6.ready", {31'd0, bus_if.id_ready}, 32'd1);
      cyc(); idle_in();                                           // t=7
      cyc(); op(1'b0, 5'd1, 5'd2, 5'd10, 1'b1, 32'h55);           // t=8 cnt==1
      mid(); chk("W.t8.ready", {31'd0, bus_if.id_ready}, 32'd0);
      cyc(); bus_if.long_rd_data = 32'h99;                        // t=9 DONE
      mid(); chk_wb("W.t9.wb", 1'b1, 5'd9, 32'h99);
      chk("W.t9.ready", {31'd0, bus_if.id_ready}, 32'd1);
      cyc(); idle_in(); bus_if.long_rd_data = 32'd0;              // t=10
      mid(); chk_wb("W.t10.wb", 1'b1, 5'd10, 32'h55);
      chk("W.t10.stall", bus_if.stall_cycles, 32'd9);

      // ---------------- reset mid-RUN (test 6) ----------------
      cyc(); op(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 32'd0);            // t=0
      cyc(); idle_in();                                           // t=1
      cyc(); cyc();                                               // t=2,3
      cyc(); rst = 1'b1;                                          // t=4
      cyc(); rst = 1'b0;                                          // t=5
      op(1'b0, 5'd12, 5'd0, 5'd6, 1'b1, 32'h66);
      mid(); chk("R.t5.busy",  {31'd0, bus_if.busy}, 32'd0);
      chk("R.t5.start", {31'd0, bus_if.long_start}, 32'd0);
      chk("R.t5.ready", {31'd0, bus_if.id_ready}, 32'd1);
      chk("R.t5.stall", bus_if.stall_cycles, 32'd0);
      chk_wb("R.t5.wb", 1'b0, 5'd0, 32'd0);
      cyc(); idle_in(); bus_if.long_rd_data = 32'hBAD0;           // t=6
      mid(); chk_wb("R.t6.wb", 1'b1, 5'd6, 32'h66);
      for (int t = 7; t <= 11; t++) begin
         cyc(); mid();
         chk($sformatf("R.t%0d.wen", t),  {31'd0, bus_if.wb_wen}, 32'd0);
         chk($sformatf("R.t%0d.busy", t), {31'd0, bus_if.busy}, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
